calc_addsub_n: RTL
==================

Name: calc_addsub_n

Overview:
Parametrised successor to the keypad adder. Accepts decimal operands digit-by-digit from the keypad decoder as 4-bit key codes with a one-cycle strobe. Supports add, subtract, chained operations, backspace and signed results, with saturation on overflow. Sits between the keypad scanner/debouncer and the display driver.

Parameters:
MAX_DIGITS, 4, maximum decimal digits per operand; further digits are ignored.
RES_W, 14, result magnitude width. Constraint: 10^MAX_DIGITS-1 < 2^RES_W.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_code  input  4  0-9 digit, 10 ADD, 11 EQUAL, 12 CLEAR, 13 SUB, 14 BACKSPACE, 15 ignored
key_pulse  input  1  key_code is valid this cycle; each high cycle is one key event
entry  output  RES_W  operand currently being typed (for display)
result  output  RES_W  result magnitude
result_neg  output  1  result is negative
result_valid  output  1  result holds a completed EQUAL result
result_pulse  output  1  one-cycle strobe on each EQUAL completion
overflow  output  1  last computation saturated

Behaviour:
- Reset values: all outputs 0; internal A=0, B=0, op=ADD, digit count=0; state S_OPA.
- Internal A is a signed accumulator, RES_W+2 bits.
- States:
  - S_OPA: typing A.
  - S_OPW: operator taken, no B digit yet.
  - S_OPB: typing B.
  - S_RES: result shown.
- Digit entry (S_OPA/S_OPB):
  - If count < MAX_DIGITS: operand = operand*10 + d; count++.
  - Otherwise the digit is ignored.
  - entry mirrors the operand being typed.
- BACKSPACE: operand = operand/10; count-- (floor 0). Ignored in S_OPW and S_RES.
- ADD/SUB:
  - S_OPA: store op, go to S_OPW.
  - S_OPW: replace op only.
  - S_OPB: A = A op B (chain), store new op, B=0, count=0, go to S_OPW. No result_pulse.
  - S_RES: A = signed result, store op, go to S_OPW.
- Digit in S_OPW: B = d, count=1, go to S_OPB.
- Digit in S_RES: start a new A = d. Clears result_valid and overflow. Go to S_OPA.
- EQUAL:
  - S_OPB: R = A op B.
  - S_OPA/S_OPW: R = A (pending op ignored).
  - S_RES: no action, no pulse.
  - Otherwise: on the same clock edge, result=|R|, result_neg=(R<0), result_valid=1, result_pulse=1 for exactly one cycle; go to S_RES.
- Overflow: if |R| > 2^RES_W-1 (at EQUAL or at a chain step):
  - result = 2^RES_W-1, sign kept, overflow=1, result_valid=1, result_pulse=1, go to S_RES.
  - ADD/SUB are ignored while overflow=1; only CLEAR or a digit exits.
- CLEAR (any state): same state as reset, except no asynchronous action. Synchronous, 1-cycle.
- Zero result: result_neg=0 (never negative zero).
- key_pulse with code 15: no effect.
- Asynchronous reset asserted mid-entry: all state clears immediately, without waiting for clk.

Test Plan:
1. Keys 1,5,ADD,2,7,EQUAL -> result=42, result_neg=0, result_pulse high one cycle, result_valid=1.
2. CLEAR, then 8,SUB,1,3,EQUAL -> result=5, result_neg=1. Then ADD,9,EQUAL -> result=4, result_neg=0.
3. Chain 1,0,ADD,5,SUB,3,EQUAL -> result=12. Exactly one result_pulse (at EQUAL); entry=5 after 5, entry=3 after 3.
4. 9,9,9,9,ADD,9,9,9,9,EQUAL -> overflow=1, result=16383. A following ADD is ignored. Digit 2 -> overflow=0, result_valid=0, entry=2.
5. Keys 1,2,3,4,5 -> entry=1234. BACKSPACE -> entry=123. BACKSPACE x4 -> entry=0, no underflow.
6. Digits 4,2, then rst_n low mid-stream (between clock edges) -> all outputs 0 immediately. After release, 7,EQUAL -> result=7.

Source files
------------

// File: rtl/calc_addsub_n.sv
// Keypad calculator core: digit-by-digit operand entry, chained add/subtract,
// signed result with magnitude saturation, backspace and synchronous clear.
module calc_addsub_n #(
   parameter int MAX_DIGITS = 4,
   parameter int RES_W      = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       key_code,
   input  logic             key_pulse,
   output logic [RES_W-1:0] entry,
   output logic [RES_W-1:0] result,
   output logic             result_neg,
   output logic             result_valid,
   output logic             result_pulse,
   output logic             overflow
);

   localparam int AW = RES_W + 2;
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [RES_W-1:0] MAXV = '1;

   typedef enum logic [1:0] {S_OPA, S_OPW, S_OPB, S_RES} state_t;

   state_t                r_state, w_state;
   logic signed [AW-1:0]  r_a, w_a;
   logic [RES_W-1:0]      r_b, w_b;
   logic                  r_sub, w_sub;
   logic [CW-1:0]         r_cnt, w_cnt;
   logic [RES_W-1:0]      r_result, w_result;
   logic                  r_neg, w_neg;
   logic                  r_valid, w_valid;
   logic                  r_pulse, w_pulse;
   logic                  r_ovf, w_ovf;

   logic                  w_dig, w_add, w_eq, w_clr, w_subk, w_bs, w_op;
   logic signed [AW-1:0]  w_bext, w_r, w_a_dig, w_a_bs;
   logic [RES_W-1:0]      w_b_dig;
   logic [AW-1:0]         w_mag;
   logic                  w_rovf;
   logic                  w_room;

   assign w_dig  = key_pulse && (key_code <= 4'd9);
   assign w_add  = key_pulse && (key_code == 4'd10);
   assign w_eq   = key_pulse && (key_code == 4'd11);
   assign w_clr  = key_pulse && (key_code == 4'd12);
   assign w_subk = key_pulse && (key_code == 4'd13);
   assign w_bs   = key_pulse && (key_code == 4'd14);
   // A saturated result locks out operators until a digit or CLEAR arrives.
   assign w_op   = (w_add || w_subk) && !r_ovf;

   assign w_room  = (r_cnt < CW'(MAX_DIGITS));
   assign w_a_dig = r_a * AW'(10) + AW'(key_code);
   assign w_a_bs  = $signed($unsigned(r_a) / AW'(10));
   assign w_b_dig = r_b * RES_W'(10) + RES_W'(key_code);

   // The pending computation: A op B while typing B, otherwise A alone.
   assign w_bext = $signed({2'b00, r_b});
   always_comb begin
      w_r = r_a;
      if (r_state == S_OPB) begin
         w_r = r_sub ? (r_a - w_bext) : (r_a + w_bext);
      end
   end

   assign w_mag  = w_r[AW-1] ? $unsigned(-w_r) : $unsigned(w_r);
   assign w_rovf = |w_mag[AW-1:RES_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_OPA;
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_neg    <= 1'b0;
         r_valid  <= 1'b0;
         r_pulse  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_a      <= w_a;
         r_b      <= w_b;
         r_sub    <= w_sub;
         r_cnt    <= w_cnt;
         r_result <= w_result;
         r_neg    <= w_neg;
         r_valid  <= w_valid;
         r_pulse  <= w_pulse;
         r_ovf    <= w_ovf;
      end
   end

   always_comb begin
      w_state  = r_state;
      w_a      = r_a;
      w_b      = r_b;
      w_sub    = r_sub;
      w_cnt    = r_cnt;
      w_result = r_result;
      w_neg    = r_neg;
      w_valid  = r_valid;
      w_pulse  = 1'b0;
      w_ovf    = r_ovf;

      if (w_clr) begin
         w_state  = S_OPA;
         w_a      = '0;
         w_b      = '0;
         w_sub    = 1'b0;
         w_cnt    = '0;
         w_result = '0;
         w_neg    = 1'b0;
         w_valid  = 1'b0;
         w_ovf    = 1'b0;
      end else if (w_dig) begin
         case (r_state)
            S_OPA: begin
               if (w_room) begin
                  w_a   = w_a_dig;
                  w_cnt = r_cnt + 1'b1;
               end
            end
            S_OPB: begin
               if (w_room) begin
                  w_b   = w_b_dig;
                  w_cnt = r_cnt + 1'b1;
               end
            end
            S_OPW: begin
               w_b     = RES_W'(key_code);
               w_cnt   = CW'(1);
               w_state = S_OPB;
            end
            S_RES: begin
               w_a     = $signed(AW'(key_code));
               w_cnt   = CW'(1);
               w_valid = 1'b0;
               w_ovf   = 1'b0;
               w_state = S_OPA;
            end
            default: ;
         endcase
      end else if (w_bs) begin
         if (r_state == S_OPA) begin
            w_a   = w_a_bs;
            w_cnt = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
         end else if (r_state == S_OPB) begin
            w_b   = r_b / RES_W'(10);
            w_cnt = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
         end
      end else if (w_op || (w_eq && r_state != S_RES)) begin
         if (w_op) begin
            w_sub = w_subk;
         end
         // A chain step that saturates ends the same way as an EQUAL does.
         if (w_eq || (r_state == S_OPB && w_rovf)) begin
            w_a      = w_r;
            w_result = w_rovf ? MAXV : w_mag[RES_W-1:0];
            w_neg    = w_r[AW-1];
            w_valid  = 1'b1;
            w_pulse  = 1'b1;
            w_ovf    = w_rovf;
            w_state  = S_RES;
         end else begin
            if (r_state == S_OPA || r_state == S_OPB) begin
               w_a = w_r;
            end
            w_b     = '0;
            w_cnt   = '0;
            w_state = S_OPW;
         end
      end
   end

   // The display shows A while typing it, B once an operator is pending.
   always_comb begin
      entry = '0;
      case (r_state)
         S_OPA:        entry = r_a[RES_W-1:0];
         S_OPW, S_OPB: entry = r_b;
         default:      entry = '0;
      endcase
   end

   assign result       = r_result;
   assign result_neg   = r_neg;
   assign result_valid = r_valid;
   assign result_pulse = r_pulse;
   assign overflow     = r_ovf;

endmodule
